mariocape_sprite_fetch: RTL and testbench

- Upstream pixel stage for the Mario cape sprite.
- Per VGA pixel, tests whether the pixel lies inside the cape sprite box and, if so, computes the sprite ROM address and captures the 4-bit palette index returned by the ROM.
- Owns the cape animation frame counter, advanced on vertical sync.
- The registered index feeds the cape palette lookup; pixel_valid tells the colour mux whether to use the cape colour instead of the background colour.

---
 rtl/mariocape_sprite_fetch.sv | 135 +++++++++++++
 tb/tb_mariocape_sprite_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mariocape_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : mariocape_sprite_fetch
// Brief    : Cape sprite box test, ROM address generation, palette index
//            capture and animation frame counter. Optional macro:
//            MARIOCAPE_MIRROR_EN enables horizontal flip via facing_left.
// Revision : 1.0 - initial release
// ============================================================================
module mariocape_sprite_fetch #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 8,
  parameter int ADDR_W     = 12,
  parameter int TRANSP_IDX = 0,
  localparam int FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vs,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        SpriteX,
  input  logic [9:0]        SpriteY,
  input  logic              cape_active,
  input  logic              facing_left,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        index,
  output logic              pixel_valid,
  output logic [FRAME_W-1:0] frame
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0]   C_DIV_LAST   = DIV_W'(FRAME_DIV - 1);
  localparam logic [FRAME_W-1:0] C_FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [ADDR_W-1:0]  C_FRAME_SZ   = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0]  C_ROW_SZ     = ADDR_W'(SPR_W);
  localparam logic [3:0]         C_TRANSP     = 4'(TRANSP_IDX);

  generate
    if ((NUM_FRAMES * SPR_W * SPR_H) > (2 ** ADDR_W)) begin : g_cfg_err
      $error("mariocape_sprite_fetch: ADDR_W too small for NUM_FRAMES*SPR_W*SPR_H");
    end
  endgenerate

  // ---------------- animation frame counter ----------------
  logic               r_vs_prev;
  logic [DIV_W-1:0]   r_div;
  logic [FRAME_W-1:0] r_frame;
  logic               w_vs_edge;

  assign w_vs_edge = r_vs_prev & ~vs;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vs_prev <= 1'b1;
      r_div     <= '0;
      r_frame   <= '0;
    end else begin
      r_vs_prev <= vs;
      // Parking on frame 0 wins over a coincident vsync edge.
      if (!cape_active) begin
        r_div   <= '0;
        r_frame <= '0;
      end else if (w_vs_edge) begin
        if (r_div == C_DIV_LAST) begin
          r_div   <= '0;
          r_frame <= (r_frame == C_FRAME_LAST) ? '0 : r_frame + 1'b1;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign frame = r_frame;

  // ---------------- stage 0: box test and address ----------------
  logic [9:0]        w_dx;
  logic [9:0]        w_dy;
  logic              w_inbox;
  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_addr;

  // Negative offsets wrap to large values, so off-screen parts clip naturally.
  assign w_dx    = DrawX - SpriteX;
  assign w_dy    = DrawY - SpriteY;
  assign w_inbox = (32'(w_dx) < 32'(SPR_W)) && (32'(w_dy) < 32'(SPR_H));

`ifdef MARIOCAPE_MIRROR_EN
  assign w_col = (w_inbox && facing_left) ? (ADDR_W'(SPR_W - 1) - ADDR_W'(w_dx))
                                          : ADDR_W'(w_dx);
`else
  logic w_unused_facing;
  assign w_unused_facing = facing_left;
  assign w_col = ADDR_W'(w_dx);
`endif

  assign w_addr = (ADDR_W'(r_frame) * C_FRAME_SZ) + (ADDR_W'(w_dy) * C_ROW_SZ) + w_col;

  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_v1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rom_addr <= '0;
      r_v1       <= 1'b0;
    end else begin
      r_rom_addr <= w_inbox ? w_addr : '0;
      r_v1       <= w_inbox;
    end
  end

  assign rom_addr = r_rom_addr;

  // ---------------- stage 1: index capture ----------------
  logic [3:0] r_index;
  logic       r_pixel_valid;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_index       <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_index       <= r_v1 ? rom_q : C_TRANSP;
      r_pixel_valid <= r_v1 && (rom_q != C_TRANSP);
    end
  end

  assign index       = r_index;
  assign pixel_valid = r_pixel_valid;

endmodule
`default_nettype wire

// File: tb/tb_mariocape_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mariocape_sprite_fetch
// Brief    : Self-checking bench: vector table through a latency scoreboard,
//            plus hand sequences for reset, animation and frame offset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mariocape_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        vs;
  logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
  logic        cape_active, facing_left;
  logic [11:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  index;
  logic        pixel_valid;
  logic [1:0]  frame;

  mariocape_sprite_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .vs(vs),
    .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
    .cape_active(cape_active), .facing_left(facing_left),
    .rom_addr(rom_addr), .rom_q(rom_q), .index(index),
    .pixel_valid(pixel_valid), .frame(frame)
  );

  always #5 Clk = ~Clk;

  // ROM: low address nibble, with one override; read data follows the registered address.
  logic [3:0] rom_mem [0:4095];
  assign rom_q = rom_mem[rom_addr];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int ea;
    int ei;
    int ev;
    int id;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  bit   have_pend = 0;

  // Scoreboard: address one cycle after drive, index/valid one cycle later.
  always @(posedge Clk) begin
    #1;
    if (have_pend) begin
      chk($sformatf("sb%0d_index", pend.id), int'(index), pend.ei);
      chk($sformatf("sb%0d_valid", pend.id), int'(pixel_valid), pend.ev);
      have_pend = 0;
    end
    if (exp_q.size() > 0) begin
      pend = exp_q.pop_front();
      chk($sformatf("sb%0d_addr", pend.id), int'(rom_addr), pend.ea);
      have_pend = 1;
    end
  end

  task automatic drive_px(input logic [9:0] sx, input logic [9:0] sy,
                          input logic [9:0] x, input logic [9:0] y, input logic face,
                          input int ea, input int ei, input int ev, input int id);
    exp_t e;
    @(negedge Clk);
    SpriteX = sx; SpriteY = sy; DrawX = x; DrawY = y; facing_left = face;
    e.ea = ea; e.ei = ei; e.ev = ev; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    repeat (3) @(negedge Clk);
  endtask

  task automatic vs_pulse(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk); vs = 1'b0;
      @(negedge Clk); vs = 1'b1;
    end
  endtask

  typedef struct {
    logic [9:0] sx, sy, x, y;
    logic       face;
    int         ea, ei, ev;
  } vec_t;

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 4096; a++) rom_mem[a] = 4'(a);
    rom_mem[101] = 4'd7;

    vt[0]  = '{10'd100, 10'd50,   10'd105, 10'd53, 1'b0, 101,  7, 1};
    vt[1]  = '{10'd100, 10'd50,   10'd100, 10'd50, 1'b0,   0,  0, 0};
    vt[2]  = '{10'd100, 10'd50,   10'd131, 10'd81, 1'b0, 1023, 15, 1};
    vt[3]  = '{10'd100, 10'd50,   10'd132, 10'd50, 1'b0,   0,  0, 0};
    vt[4]  = '{10'd100, 10'd50,   10'd99,  10'd50, 1'b0,   0,  0, 0};
    vt[5]  = '{10'd100, 10'd50,   10'd110, 10'd82, 1'b0,   0,  0, 0};
    vt[6]  = '{10'd1000, 10'd50,  10'd2,   10'd50, 1'b0,  26, 10, 1};
    vt[7]  = '{10'd1000, 10'd50,  10'd40,  10'd50, 1'b0,   0,  0, 0};
    vt[8]  = '{10'd100, 10'd1020, 10'd100, 10'd3,  1'b0, 224,  0, 0};
    vt[9]  = '{10'd100, 10'd50,   10'd117, 10'd60, 1'b0, 337,  1, 1};
`ifdef MARIOCAPE_MIRROR_EN
    vt[10] = '{10'd100, 10'd50,   10'd100, 10'd50, 1'b1,  31, 15, 1};
    vt[11] = '{10'd100, 10'd50,   10'd105, 10'd53, 1'b1, 122, 10, 1};
`else
    vt[10] = '{10'd100, 10'd50,   10'd100, 10'd50, 1'b1,   0,  0, 0};
    vt[11] = '{10'd100, 10'd50,   10'd105, 10'd53, 1'b1, 101,  7, 1};
`endif

    // Reset held with sprite under the raster.
    Reset_n = 1'b0; vs = 1'b1; cape_active = 1'b1; facing_left = 1'b0;
    SpriteX = 10'd100; SpriteY = 10'd50; DrawX = 10'd105; DrawY = 10'd53;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_index", int'(index), 0);
    chk("rst_valid", int'(pixel_valid), 0);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_frame", int'(frame), 0);

    @(negedge Clk); DrawX = 10'd300;
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk); DrawX = 10'd105;
    @(posedge Clk); #1;
    chk("lat_addr_n1", int'(rom_addr), 101);
    chk("lat_valid_n1", int'(pixel_valid), 0);
    @(posedge Clk); #1;
    chk("lat_index_n2", int'(index), 7);
    chk("lat_valid_n2", int'(pixel_valid), 1);
    @(negedge Clk); DrawX = 10'd300;
    drain();

    for (int i = 0; i < 12; i++)
      drive_px(vt[i].sx, vt[i].sy, vt[i].x, vt[i].y, vt[i].face,
               vt[i].ea, vt[i].ei, vt[i].ev, i);
    @(negedge Clk); DrawX = 10'd300; facing_left = 1'b0;
    drain();

    // Animation stepping and wrap.
    vs_pulse(7);
    chk("anim_7_edges", int'(frame), 0);
    vs_pulse(1);
    chk("anim_8_edges", int'(frame), 1);
    vs_pulse(24);
    chk("anim_32_wrap", int'(frame), 0);
    vs_pulse(16);
    chk("anim_frame2", int'(frame), 2);

    drive_px(10'd100, 10'd50, 10'd100, 10'd50, 1'b0, 2048, 0, 0, 100);
    drive_px(10'd100, 10'd50, 10'd101, 10'd50, 1'b0, 2049, 1, 1, 101);
    drive_px(10'd100, 10'd50, 10'd131, 10'd81, 1'b0, 3071, 15, 1, 102);
    @(negedge Clk); DrawX = 10'd300;
    drain();

    // Reset mid-frame, asserted between clock edges.
    @(negedge Clk); DrawX = 10'd101;
    repeat (2) @(posedge Clk);
    #1;
    chk("pre_midrst_valid", int'(pixel_valid), 1);
    #2; Reset_n = 1'b0; #1;
    chk("midrst_valid", int'(pixel_valid), 0);
    chk("midrst_index", int'(index), 0);
    chk("midrst_addr", int'(rom_addr), 0);
    chk("midrst_frame", int'(frame), 0);
    repeat (2) @(negedge Clk);
    DrawX = 10'd300;
    @(negedge Clk); Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("postrst_valid%0d", k), int'(pixel_valid), 0);
    end

    // cape_active drop on an edge cycle clears frame and divider.
    vs_pulse(11);
    chk("drop_pre_frame", int'(frame), 1);
    @(negedge Clk); vs = 1'b0; cape_active = 1'b0;
    @(negedge Clk); vs = 1'b1; cape_active = 1'b1;
    chk("drop_frame", int'(frame), 0);
    vs_pulse(7);
    chk("drop_div_7", int'(frame), 0);
    vs_pulse(1);
    chk("drop_div_8", int'(frame), 1);

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
